cache_nway: RTL

- Parametrised N-way set-associative instruction cache with true-LRU replacement. It is the successor to the fixed 2-way, 4-set cache.
- Sits between the fetch stage (PC request/response) and main memory. Main memory is reached over a req/ack fill handshake.
- Set count, way count, data width and counter width are configurable.
- Adds over the 2-way cache: invalid-way-first victim selection, flush, an explicit fill handshake, and saturating hit/miss counters.

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_lru_nway.sv | 50 +++++
 rtl/cache_nway.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the N-way instruction cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, MISS, FLUSH_PEND} state_t;

  // Callers cast the 64-bit result down to their own index/tag width.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/cache_lru_nway.sv
// Per-set true-LRU age tracking and victim choice (invalid ways are preferred).
module cache_lru_nway
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 4,
  localparam int AGE_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             access,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [AGE_W-1:0] access_way,
  input  logic [WAYS-1:0]  valid,
  output logic [AGE_W-1:0] victim
);

  logic [AGE_W-1:0] age [SETS][WAYS];
  logic [AGE_W-1:0] lru_way;

  // Ages stay a permutation of 0..WAYS-1; age 0 is the most recently used way.
  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else if (access) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == access_way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < age[set_idx][access_way])
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set_idx][w] == AGE_W'(WAYS - 1))
        lru_way = AGE_W'(w);
    victim = lru_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w])
        victim = AGE_W'(w);
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative instruction cache with single-word lines, req/ack fill and flush.
module cache_nway
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 4,
  parameter int SETS   = 4,
  parameter int CNT_W  = 20,
  localparam int IDX_W = $clog2(SETS),
  localparam int AGE_W = $clog2(WAYS),
  localparam int TAG_W = ADDR_W - 2 - IDX_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] PC,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  CNT_HIT,
  output logic [CNT_W-1:0]  CNT_MISS
);

  state_t state;
  logic   flush_latched;

  logic [WAYS-1:0]   valid_mem [SETS];
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [DATA_W-1:0] data_mem  [SETS][WAYS];

  logic [IDX_W-1:0] req_idx, miss_idx, lru_set;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             hit, lookup, fill, lru_access, lru_flush;
  logic [AGE_W-1:0] hit_way, victim, access_way;

  // mem_addr holds the captured PC for the whole miss, so the fill target derives from it.
  assign req_idx  = IDX_W'(pc_index(64'(PC), IDX_W));
  assign req_tag  = TAG_W'(pc_tag(64'(PC), IDX_W));
  assign miss_idx = IDX_W'(pc_index(64'(mem_addr), IDX_W));
  assign miss_tag = TAG_W'(pc_tag(64'(mem_addr), IDX_W));

  assign lookup     = (state == IDLE) && req_valid && !flush;
  assign fill       = (state == MISS) && mem_ack;
  assign lru_access = (lookup && hit) || fill;
  assign lru_set    = (state == IDLE) ? req_idx : miss_idx;
  assign access_way = fill ? victim : hit_way;
  assign lru_flush  = ((state == IDLE) && flush) || (state == FLUSH_PEND);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  cache_lru_nway #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .CLK        (CLK),
    .RESET      (RESET),
    .flush      (lru_flush),
    .access     (lru_access),
    .set_idx    (lru_set),
    .access_way (access_way),
    .valid      (valid_mem[lru_set]),
    .victim     (victim)
  );

  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[miss_idx][victim]  <= miss_tag;
      data_mem[miss_idx][victim] <= mem_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_data      <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      CNT_HIT       <= '0;
      CNT_MISS      <= '0;
      flush_latched <= 1'b0;
      for (int s = 0; s < SETS; s++) valid_mem[s] <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) valid_mem[s] <= '0;
          end else if (req_valid) begin
            if (hit) begin
              rsp_valid <= 1'b1;
              rsp_hit   <= 1'b1;
              rsp_data  <= data_mem[req_idx][hit_way];
              if (CNT_HIT != '1) CNT_HIT <= CNT_HIT + 1'b1;
            end else begin
              mem_addr      <= PC;
              mem_req       <= 1'b1;
              req_ready     <= 1'b0;
              flush_latched <= 1'b0;
              state         <= MISS;
              if (CNT_MISS != '1) CNT_MISS <= CNT_MISS + 1'b1;
            end
          end
        end
        MISS: begin
          if (flush) flush_latched <= 1'b1;
          if (mem_ack) begin
            valid_mem[miss_idx][victim] <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b0;
            rsp_data  <= mem_data;
            mem_req   <= 1'b0;
            if (flush || flush_latched) begin
              state <= FLUSH_PEND;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
        end
        FLUSH_PEND: begin
          for (int s = 0; s < SETS; s++) valid_mem[s] <= '0;
          flush_latched <= 1'b0;
          req_ready     <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
